serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//  Downstream consumer of the 1-bit storage register stage. Samples the registered serial bit
//  (out of the 1-bit register) whenever the upstream write enable qualifies it, and assembles
//  WIDTH bits into a parallel word. Presents the word with a valid/ready handshake to the next
//  stage and back-pressures the upstream register via din_ready.
// PARAMETERS
//  WIDTH      8   data bits per word (>=2)
//  MSB_FIRST  0   0: first accepted bit lands in pout[0]; 1: first accepted bit lands in pout[WIDTH-1]
// PORTS
//  clk          input   1      single clock; all logic on posedge clk
//  reset        input   1      synchronous, active-high reset
//  din          input   1      serial data bit (registered output of upstream 1-bit register)
//  din_valid    input   1      din qualifier (upstream we); bit accepted when din_valid && din_ready
//  din_ready    output  1      collector can accept a bit this cycle
//  pout         output  WIDTH  assembled word; stable while pout_valid=1
//  pout_valid   output  1      word available
//  pout_ready   input   1      downstream accepts word when pout_valid && pout_ready
//  overrun      output  1      sticky: din_valid seen while din_ready=0 (bit dropped)
//  parity_err   output  1      word failed even-parity check (PARITY_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (sync, high, sampled on posedge clk): state=FILL, bit count=0, shift reg=0, pout=0,
//    pout_valid=0, overrun=0, parity_err=0. Reset overrides every other event that cycle,
//    including a word mid-fill (partial bits discarded) or a word held in HOLD (word lost).
//  - States: FILL (collecting), HOLD (word complete, waiting for pout_ready).
//  - FILL: din_ready=1. On accept, shift din in (MSB_FIRST=0: sr<={din,sr[WIDTH-1:1]};
//    MSB_FIRST=1: sr<={sr[WIDTH-2:0],din}), count++. din_valid=0 -> no change (gaps allowed).
//  - Frame length F = WIDTH (WIDTH+1 with PARITY_EN). Accept of bit F-1 -> count=0, pout<=final
//    word, pout_valid=1, state=HOLD on the next edge. Latency: pout_valid high 1 cycle after the
//    edge sampling the last bit.
//  - HOLD: pout, pout_valid, parity_err held. din_ready = pout_ready (combinational).
//    pout_ready=1 -> pout_valid=0, state=FILL next edge; pout keeps its last value.
//  - Simultaneous pout_ready && din_valid in HOLD: word handed off AND din accepted as bit 0 of
//    next word, count=1, state=FILL -> no bubble; back-to-back words at 1 bit/cycle sustained.
//  - din_valid && !din_ready: bit dropped, overrun<=1, stays 1 until reset.
//  - Counter width $clog2(WIDTH+2); never exceeds F-1; no wrap other than F-1 -> 0.
//  - pout_valid never drops without pout_ready (no retraction).
// CONFIGURATION
//  PARITY_EN defined: frame = WIDTH data bits then 1 parity bit (not stored in pout). When the
//    word completes, parity_err = XOR(data bits, parity bit) (even parity: 0 = good), valid with
//    pout_valid, held through HOLD, cleared on handoff or reset. Words with errors are still
//    delivered.
//  PARITY_EN undefined: frame = WIDTH bits; parity_err constant 0; no parity logic synthesised.
// TESTING (WIDTH=8, MSB_FIRST=0 unless stated)
//  1 reset=1 two cycles -> pout=0x00, pout_valid=0, din_ready=1, overrun=0.
//  2 din_valid=1, din=1,0,1,0,0,1,0,1 on 8 consecutive cycles, pout_ready=0 -> pout=0xA5,
//    pout_valid=1 one cycle after 8th bit, din_ready=0; assert pout_ready -> pout_valid=0 next cycle.
//  3 MSB_FIRST=1, same bit sequence -> pout=0xA5 reversed = 0xA5 (palindrome); then bits
//    1,1,0,0,0,0,0,0 -> pout=0xC0.
//  4 Word held (pout_valid=1, pout_ready=0), din_valid=1 for 1 cycle -> overrun=1, bit dropped,
//    pout unchanged; overrun stays 1 until reset.
//  5 pout_ready=1 tied, din_valid=1 continuously for 16 cycles of 0x3C,0x81 bit streams ->
//    two words 0x3C then 0x81, pout_valid high 8 cycles apart, no dropped bits, overrun=0.
//  6 PARITY_EN: bits of 0x07 then parity 1 -> pout=0x07, parity_err=0; parity 0 -> parity_err=1.
//    Reset after 4 bits of a word -> next 8 bits form a fresh word.

Source files
------------

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - serial-to-parallel word collector with valid/ready output handshake
// Optional even-parity frame bit enabled by defining PARITY_EN.
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = '0;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pout_valid_q, pout_valid_d;
  logic             overrun_q, overrun_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0] sr_shift;
  logic             ready_c;

  always_comb begin
    if (MSB_FIRST != 0) begin
      sr_shift = {sr_q[WIDTH-2:0], din};
    end else begin
      sr_shift = {din, sr_q[WIDTH-1:1]};
    end
    // In HOLD a bit can only be taken when the held word leaves in the same cycle.
    ready_c = (state_q == S_FILL) || pout_ready;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    overrun_d    = overrun_q;
`ifdef PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif

    if (din_valid && !ready_c) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_FILL: begin
        if (din_valid) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d        = ZERO;
            pout_valid_d = 1'b1;
            state_d      = S_HOLD;
`ifdef PARITY_EN
            // Final bit is the parity bit; data already sits complete in sr_q.
            pout_d       = sr_q;
            parity_err_d = par_q ^ din;
            par_d        = 1'b0;
`else
            pout_d       = sr_shift;
            sr_d         = sr_shift;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
            sr_d  = sr_shift;
`ifdef PARITY_EN
            par_d = par_q ^ din;
`endif
          end
        end
      end
      default: begin
        if (pout_ready) begin
          pout_valid_d = 1'b0;
          state_d      = S_FILL;
`ifdef PARITY_EN
          parity_err_d = 1'b0;
`endif
          // Accepting the first bit of the next word here avoids a bubble.
          if (din_valid) begin
            sr_d  = sr_shift;
            cnt_d = ONE;
`ifdef PARITY_EN
            par_d = din;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      cnt_q        <= ZERO;
      sr_q         <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overrun_q    <= overrun_d;
`ifdef PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign din_ready  = ready_c;
  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign overrun    = overrun_q;
`ifdef PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - bench for serial_word_collector (LSB-first and MSB-first instances)
// Honours PARITY_EN when defined for the build.
module tb_serial_word_collector;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int F   = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int F   = W;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic pout_ready = 1'b0;
  logic ready_l, ready_m, valid_l, valid_m, ovr_l, ovr_m, perr_l, perr_m;
  logic [W-1:0] pout_l, pout_m;

  int num_checks = 0;
  int num_errors = 0;

  // Reference model: queue of accepted frame bits plus the word on offer.
  bit           q[$];
  bit           m_valid, m_ovr, m_perr;
  logic [W-1:0] m_pout_l, m_pout_m;
  logic         obs_ready, exp_ready;

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready_l),
    .pout(pout_l), .pout_valid(valid_l), .pout_ready(pout_ready), .overrun(ovr_l),
    .parity_err(perr_l)
  );

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(ready_m),
    .pout(pout_m), .pout_valid(valid_m), .pout_ready(pout_ready), .overrun(ovr_m),
    .parity_err(perr_m)
  );

  task automatic model_reset();
    q.delete();
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_perr   = 1'b0;
    m_pout_l = '0;
    m_pout_m = '0;
  endtask

  task automatic model_edge(input bit v, input bit d, input bit r);
    bit rdy;
    bit par;
    rdy = !m_valid || r;
    if (v && !rdy) m_ovr = 1'b1;
    if (m_valid && r) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
    if (v && rdy) begin
      q.push_back(d);
      if (q.size() == F) begin
        m_pout_l = '0;
        m_pout_m = '0;
        par = 1'b0;
        for (int i = 0; i < W; i++) begin
          m_pout_l = m_pout_l | (W'(q[i]) << i);
          m_pout_m = m_pout_m | (W'(q[i]) << (W - 1 - i));
        end
        for (int i = 0; i < F; i++) par = par ^ q[i];
        m_perr  = PAR ? par : 1'b0;
        m_valid = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic drive_cycle(input bit v, input bit d, input bit r);
    @(negedge clk);
    din_valid  = v;
    din        = d;
    pout_ready = r;
    #1;
    obs_ready = ready_l;
    exp_ready = !m_valid || r;
    model_edge(v, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    din_valid  = 1'b0;
    din        = 1'b0;
    pout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic bit frame_bit(input logic [W-1:0] w, input int i, input bit flip);
    if (i < W) return w[i];
    return (^w) ^ flip;
  endfunction

  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = 0; i < F; i++) drive_cycle(1'b1, frame_bit(w, i, 1'b0), r);
  endtask

  task automatic test_reset();
    do_reset();
    num_checks++; if (pout_l !== 8'h00) begin num_errors++; $display("FAIL reset_pout got %h want 00", pout_l); end
    num_checks++; if (pout_m !== 8'h00) begin num_errors++; $display("FAIL reset_pout_msb got %h want 00", pout_m); end
    num_checks++; if (valid_l !== 1'b0) begin num_errors++; $display("FAIL reset_valid got %b want 0", valid_l); end
    num_checks++; if (ready_l !== 1'b1) begin num_errors++; $display("FAIL reset_ready got %b want 1", ready_l); end
    num_checks++; if (ovr_l !== 1'b0) begin num_errors++; $display("FAIL reset_overrun got %b want 0", ovr_l); end
    num_checks++; if (perr_l !== 1'b0) begin num_errors++; $display("FAIL reset_parity got %b want 0", perr_l); end
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    w = 8'hA5;
    for (int i = 0; i < F; i++) begin
      drive_cycle(1'b1, frame_bit(w, i, 1'b0), 1'b0);
      if (i == F - 2) begin
        num_checks++; if (valid_l !== 1'b0) begin num_errors++; $display("FAIL basic_early_valid got %b want 0", valid_l); end
      end
    end
    num_checks++; if (valid_l !== 1'b1) begin num_errors++; $display("FAIL basic_valid got %b want 1", valid_l); end
    num_checks++; if (pout_l !== 8'hA5) begin num_errors++; $display("FAIL basic_pout got %h want a5", pout_l); end
    num_checks++; if (pout_m !== 8'hA5) begin num_errors++; $display("FAIL basic_pout_msb got %h want a5", pout_m); end
    num_checks++; if (ready_l !== 1'b0) begin num_errors++; $display("FAIL basic_ready_hold got %b want 0", ready_l); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    num_checks++; if (valid_l !== 1'b0) begin num_errors++; $display("FAIL basic_handoff got %b want 0", valid_l); end
    num_checks++; if (pout_l !== 8'hA5) begin num_errors++; $display("FAIL basic_pout_kept got %h want a5", pout_l); end
  endtask

  task automatic test_msb_first();
    send_word(8'h03, 1'b0);
    num_checks++; if (pout_m !== 8'hC0) begin num_errors++; $display("FAIL msb_pout got %h want c0", pout_m); end
    num_checks++; if (pout_l !== 8'h03) begin num_errors++; $display("FAIL msb_lsb_pout got %h want 03", pout_l); end
    num_checks++; if (valid_m !== 1'b1) begin num_errors++; $display("FAIL msb_valid got %b want 1", valid_m); end
    drive_cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_word(8'h96, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    num_checks++; if (ovr_l !== 1'b1) begin num_errors++; $display("FAIL ovr_set got %b want 1", ovr_l); end
    num_checks++; if (pout_l !== 8'h96) begin num_errors++; $display("FAIL ovr_pout got %h want 96", pout_l); end
    num_checks++; if (valid_l !== 1'b1) begin num_errors++; $display("FAIL ovr_valid got %b want 1", valid_l); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    send_word(8'h11, 1'b1);
    num_checks++; if (ovr_l !== 1'b1) begin num_errors++; $display("FAIL ovr_sticky got %b want 1", ovr_l); end
    num_checks++; if (pout_l !== 8'h11) begin num_errors++; $display("FAIL ovr_next_word got %h want 11", pout_l); end
    do_reset();
    num_checks++; if (ovr_l !== 1'b0) begin num_errors++; $display("FAIL ovr_cleared got %b want 0", ovr_l); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seen[$];
    int           at[$];
    logic [W-1:0] words[2];
    words[0] = 8'h3C;
    words[1] = 8'h81;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < F; i++) begin
        drive_cycle(1'b1, frame_bit(words[k], i, 1'b0), 1'b1);
        num_checks++; if (obs_ready !== 1'b1) begin num_errors++; $display("FAIL b2b_ready got %b want 1", obs_ready); end
        if (valid_l === 1'b1) begin
          seen.push_back(pout_l);
          at.push_back(k * F + i);
        end
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1);
    num_checks++; if (seen.size() !== 2) begin num_errors++; $display("FAIL b2b_count got %0d want 2", seen.size()); end
    if (seen.size() == 2) begin
      num_checks++; if (seen[0] !== 8'h3C) begin num_errors++; $display("FAIL b2b_word0 got %h want 3c", seen[0]); end
      num_checks++; if (seen[1] !== 8'h81) begin num_errors++; $display("FAIL b2b_word1 got %h want 81", seen[1]); end
      num_checks++; if (at[1] - at[0] !== F) begin num_errors++; $display("FAIL b2b_gap got %0d want %0d", at[1] - at[0], F); end
    end
    num_checks++; if (ovr_l !== 1'b0) begin num_errors++; $display("FAIL b2b_overrun got %b want 0", ovr_l); end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    send_word(8'h5A, 1'b0);
    num_checks++; if (pout_l !== 8'h5A) begin num_errors++; $display("FAIL midreset_pout got %h want 5a", pout_l); end
    num_checks++; if (valid_l !== 1'b1) begin num_errors++; $display("FAIL midreset_valid got %b want 1", valid_l); end
    do_reset();
    num_checks++; if (valid_l !== 1'b0) begin num_errors++; $display("FAIL holdreset_valid got %b want 0", valid_l); end
    num_checks++; if (pout_l !== 8'h00) begin num_errors++; $display("FAIL holdreset_pout got %h want 00", pout_l); end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    do_reset();
    for (int i = 0; i < F; i++) drive_cycle(1'b1, (i < W) ? (i < 3) : 1'b1, 1'b0);
    num_checks++; if (pout_l !== 8'h07) begin num_errors++; $display("FAIL par_good_pout got %h want 07", pout_l); end
    num_checks++; if (perr_l !== 1'b0) begin num_errors++; $display("FAIL par_good got %b want 0", perr_l); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < F; i++) drive_cycle(1'b1, (i < W) ? (i < 3) : 1'b0, 1'b0);
    num_checks++; if (perr_l !== 1'b1) begin num_errors++; $display("FAIL par_bad got %b want 1", perr_l); end
    drive_cycle(1'b0, 1'b0, 1'b1);
    num_checks++; if (perr_l !== 1'b0) begin num_errors++; $display("FAIL par_clear got %b want 0", perr_l); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_cycle($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 1) == 1);
      num_checks++; if (obs_ready !== exp_ready) begin num_errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, obs_ready, exp_ready); end
      num_checks++; if (valid_l !== m_valid) begin num_errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, valid_l, m_valid); end
      num_checks++; if (pout_l !== m_pout_l) begin num_errors++; $display("FAIL rnd_pout cyc %0d got %h want %h", c, pout_l, m_pout_l); end
      num_checks++; if (pout_m !== m_pout_m) begin num_errors++; $display("FAIL rnd_pout_msb cyc %0d got %h want %h", c, pout_m, m_pout_m); end
      num_checks++; if (ovr_l !== m_ovr) begin num_errors++; $display("FAIL rnd_overrun cyc %0d got %b want %b", c, ovr_l, m_ovr); end
      num_checks++; if (perr_l !== m_perr) begin num_errors++; $display("FAIL rnd_parity cyc %0d got %b want %b", c, perr_l, m_perr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_msb_first();
    test_overrun();
    test_back_to_back();
    test_reset_midword();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
